// File: rtl/utils_pkg.sv
// Shared LSU types: execute-side op, trap info, bus master FSM states and the
// alignment rule used when an op is captured.
package utils_pkg;

    typedef enum logic [1:0] {
        LSU_NONE  = 2'd0,
        LSU_LOAD  = 2'd1,
        LSU_STORE = 2'd2
    } lsu_op_typ_t;

    typedef enum logic [2:0] {
        LSU_B  = 3'd0,
        LSU_BU = 3'd1,
        LSU_H  = 3'd2,
        LSU_HU = 3'd3,
        LSU_W  = 3'd4
    } lsu_width_t;

    typedef struct packed {
        lsu_op_typ_t op_typ;
        lsu_width_t  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } s_lsu_op_t;

    typedef struct packed {
        logic        active;
        logic [31:0] mtval;
    } s_trap_info_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_fsm_t;

    // Byte accesses can never be misaligned.
    function automatic logic is_misaligned(lsu_width_t width, logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (width)
            LSU_H, LSU_HU: mis = offset[0];
            LSU_W:         mis = (offset != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the LSU: byte enables and lane-replicated store data,
// plus extraction and sign/zero extension of load data from a 32-bit bus word.
module lsu_align
    import utils_pkg::*;
(
    input  lsu_width_t  width,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Halves are only ever at offset 0 or 2, so one byte-granular shift serves both.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        byte_s  = signed'(shifted[7:0]);
        half_s  = signed'(shifted[15:0]);
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = shifted;
        case (width)
            LSU_B: begin
                be      = 4'b0001 << offset;
                wdata   = {4{st_data[7:0]}};
                ld_data = 32'(byte_s);
            end
            LSU_BU: begin
                be      = 4'b0001 << offset;
                wdata   = {4{st_data[7:0]}};
                ld_data = {24'h000000, shifted[7:0]};
            end
            LSU_H: begin
                be      = 4'b0011 << offset;
                wdata   = {2{st_data[15:0]}};
                ld_data = 32'(half_s);
            end
            LSU_HU: begin
                be      = 4'b0011 << offset;
                wdata   = {2{st_data[15:0]}};
                ld_data = {16'h0000, shifted[15:0]};
            end
            default: begin
                be      = 4'b1111;
                wdata   = st_data;
                ld_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: captures one op from execute, issues a single
// req/gnt/rvalid bus transaction and reports load data or traps.
module lsu_bus_master
    import utils_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  s_lsu_op_t    lsu_i,
    output logic         lsu_bp_o,
    output logic [31:0]  ld_data_o,
    output logic         ld_valid_o,
    output s_trap_info_t trap_ld_o,
    output s_trap_info_t trap_st_o,
    output logic         fault_o,
    output logic         req_o,
    output logic [31:0]  addr_o,
    output logic         we_o,
    output logic [3:0]   be_o,
    output logic [31:0]  wdata_o,
    input  logic         gnt_i,
    input  logic         rvalid_i,
    input  logic [31:0]  rdata_i,
    input  logic         err_i
);

    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

    lsu_fsm_t         state;
    lsu_fsm_t         state_nxt;
    s_lsu_op_t        op_q;
    logic             mis_q;
    logic [CNT_W-1:0] to_cnt;

    logic        capture;
    logic        mis_now;
    logic        timeout_hit;
    logic        rsp_ok;
    logic        bus_fault;
    logic        is_load;
    logic        is_store;
    logic        bus_on;
    logic        trap_any;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld;

    assign capture     = (state == IDLE) && (lsu_i.op_typ != LSU_NONE);
    assign mis_now     = is_misaligned(lsu_i.width, lsu_i.addr[1:0]);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST_C);
    assign is_load     = (op_q.op_typ == LSU_LOAD);
    assign is_store    = (op_q.op_typ == LSU_STORE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mis_q <= 1'b0;
        end else begin
            state <= state_nxt;
            mis_q <= capture && mis_now;
        end
    end

    // The captured op is pure data; every output that exposes it is qualified by control.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_q <= lsu_i;
        end
    end

    // Cleared whenever outside WAIT_RSP, so it restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst || (state != WAIT_RSP)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        rsp_ok    = 1'b0;
        bus_fault = 1'b0;
        case (state)
            IDLE: begin
                if (capture && !mis_now) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (gnt_i) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rvalid_i) begin
                    state_nxt = IDLE;
                    bus_fault = err_i;
                    rsp_ok    = !err_i;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                    bus_fault = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    lsu_align u_align (
        .width   (op_q.width),
        .offset  (op_q.addr[1:0]),
        .st_data (op_q.wdata),
        .rdata   (rdata_i),
        .be      (al_be),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    // Outputs are gated with rst so they read as zero for the whole reset cycle,
    // including a cycle where the state register has not yet been cleared.
    assign bus_on   = (state == REQ) && !rst;
    assign req_o    = bus_on;
    assign addr_o   = bus_on ? {op_q.addr[31:2], 2'b00} : 32'h0;
    assign we_o     = bus_on && is_store;
    assign be_o     = bus_on ? al_be : 4'h0;
    assign wdata_o  = bus_on ? al_wdata : 32'h0;
    assign lsu_bp_o = (state != IDLE) && !rst;

    assign ld_valid_o = rsp_ok && is_load && !rst;
    assign ld_data_o  = ld_valid_o ? al_ld : 32'h0;

    // A misaligned trap only fires from IDLE and a bus fault only from WAIT_RSP,
    // so the two sources never coincide.
    assign trap_any = !rst && (mis_q || bus_fault);
    assign fault_o  = !rst && bus_fault;

    always_comb begin
        trap_ld_o        = '0;
        trap_st_o        = '0;
        trap_ld_o.active = trap_any && is_load;
        trap_st_o.active = trap_any && is_store;
        if (trap_ld_o.active) begin
            trap_ld_o.mtval = op_q.addr;
        end
        if (trap_st_o.active) begin
            trap_st_o.mtval = op_q.addr;
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: stimulus pushes expected bus requests,
// load results and traps (with their cycle) and a monitor pops and compares them.
module tb_lsu_bus_master;
    import utils_pkg::*;

    localparam int TMO = 8;
    localparam int K_REQ = 0;
    localparam int K_LD  = 1;
    localparam int K_TLD = 2;
    localparam int K_TST = 3;

    logic         clk = 1'b0;
    logic         rst;
    s_lsu_op_t    lsu_i;
    logic         lsu_bp_o;
    logic [31:0]  ld_data_o;
    logic         ld_valid_o;
    s_trap_info_t trap_ld_o;
    s_trap_info_t trap_st_o;
    logic         fault_o;
    logic         req_o;
    logic [31:0]  addr_o;
    logic         we_o;
    logic [3:0]   be_o;
    logic [31:0]  wdata_o;
    logic         gnt_i;
    logic         rvalid_i;
    logic [31:0]  rdata_i;
    logic         err_i;

    lsu_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_i      (lsu_i),
        .lsu_bp_o   (lsu_bp_o),
        .ld_data_o  (ld_data_o),
        .ld_valid_o (ld_valid_o),
        .trap_ld_o  (trap_ld_o),
        .trap_st_o  (trap_st_o),
        .fault_o    (fault_o),
        .req_o      (req_o),
        .addr_o     (addr_o),
        .we_o       (we_o),
        .be_o       (be_o),
        .wdata_o    (wdata_o),
        .gnt_i      (gnt_i),
        .rvalid_i   (rvalid_i),
        .rdata_i    (rdata_i),
        .err_i      (err_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] val;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_exp(input int kind_seen, output exp_t e, output bit ok);
        e = '{default: 0};
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d want none (cycle %0d)", kind_seen, cyc);
            ok = 1'b0;
        end else begin
            e  = q.pop_front();
            ok = 1'b1;
            chk("event_kind", 32'(kind_seen), 32'(e.kind));
        end
    endtask

    task automatic push(input int kind, input int c, input logic [31:0] val, input logic [3:0] be,
                        input logic [31:0] wd, input logic we, input logic fault);
        exp_t e;
        e.kind = kind; e.cyc = c; e.val = val; e.be = be; e.wd = wd; e.we = we; e.fault = fault;
        q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        exp_t cur;
        bit   ok;
        bit   req_ok;
        bit   in_req;
        int   tk;
        in_req = 1'b0;
        req_ok = 1'b0;
        cur    = '{default: 0};
        forever begin
            @(negedge clk);
            if (!ld_valid_o) chk("ld_data_zero", ld_data_o, 32'h0);
            chk("trap_exclusive", {31'b0, trap_ld_o.active & trap_st_o.active}, 32'h0);
            chk("trap_vs_ld", {31'b0, (trap_ld_o.active | trap_st_o.active) & ld_valid_o}, 32'h0);
            if (req_o) begin
                if (!in_req) begin
                    pop_exp(K_REQ, e, ok);
                    req_ok = ok;
                    cur    = e;
                    if (ok) chk("req_cycle", 32'(cyc), 32'(e.cyc));
                end
                if (req_ok) begin
                    chk("addr_o", addr_o, cur.val);
                    chk("be_o", {28'h0, be_o}, {28'h0, cur.be});
                    chk("wdata_o", wdata_o, cur.wd);
                    chk("we_o", {31'b0, we_o}, {31'b0, cur.we});
                end
            end
            in_req = req_o;
            if (ld_valid_o) begin
                pop_exp(K_LD, e, ok);
                if (ok) begin
                    chk("ld_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ld_data_o", ld_data_o, e.val);
                end
            end
            if (trap_ld_o.active || trap_st_o.active) begin
                tk = trap_ld_o.active ? K_TLD : K_TST;
                pop_exp(tk, e, ok);
                if (ok) begin
                    chk("trap_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mtval", trap_ld_o.active ? trap_ld_o.mtval : trap_st_o.mtval, e.val);
                    chk("fault_o", {31'b0, fault_o}, {31'b0, e.fault});
                end
            end
        end
    end

    task automatic clear_bus();
        gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
    endtask

    // rd < 0 means the response never arrives and the timeout must fire.
    task automatic do_op(input lsu_op_typ_t op, input lsu_width_t w, input logic [31:0] addr,
                         input logic [31:0] wd, input int gd, input int rd, input logic [31:0] rdata,
                         input logic err, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] eld);
        int c;
        int tk;
        @(posedge clk); #1;
        clear_bus();
        lsu_i.op_typ = op; lsu_i.width = w; lsu_i.addr = addr; lsu_i.wdata = wd;
        c  = cyc;
        tk = (op == LSU_LOAD) ? K_TLD : K_TST;
        push(K_REQ, c + 1, {addr[31:2], 2'b00}, ebe, ewd, op == LSU_STORE, 1'b0);
        if (rd < 0)          push(tk, c + 1 + gd + TMO, addr, 4'h0, 32'h0, 1'b0, 1'b1);
        else if (err)        push(tk, c + 2 + gd + rd, addr, 4'h0, 32'h0, 1'b0, 1'b1);
        else if (op == LSU_LOAD) push(K_LD, c + 2 + gd + rd, eld, 4'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        lsu_i = '0;
        gnt_i = (gd == 0);
        for (int k = 0; k < gd; k++) begin
            @(posedge clk); #1;
            gnt_i = (k == gd - 1);
        end
        @(posedge clk); #1;
        gnt_i = 1'b0;
        if (rd < 0) begin
            repeat (TMO) @(posedge clk);
        end else begin
            rdata_i  = rdata;
            err_i    = err;
            rvalid_i = (rd == 0);
            for (int k = 0; k < rd; k++) begin
                @(posedge clk); #1;
                rvalid_i = (k == rd - 1);
            end
        end
    endtask

    task automatic mis_op(input lsu_op_typ_t op, input lsu_width_t w, input logic [31:0] addr);
        @(posedge clk); #1;
        clear_bus();
        lsu_i.op_typ = op; lsu_i.width = w; lsu_i.addr = addr; lsu_i.wdata = 32'h0;
        push((op == LSU_LOAD) ? K_TLD : K_TST, cyc + 1, addr, 4'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        lsu_i = '0;
        chk("mis_bp", {31'b0, lsu_bp_o}, 32'h0);
        chk("mis_req", {31'b0, req_o}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        lsu_i = '0;
        lsu_i.op_typ = LSU_LOAD; lsu_i.width = LSU_W; lsu_i.addr = 32'h0000_0100;
        clear_bus();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, req_o}, 32'h0);
        chk("rst_bp", {31'b0, lsu_bp_o}, 32'h0);
        chk("rst_we", {31'b0, we_o}, 32'h0);
        chk("rst_ldv", {31'b0, ld_valid_o}, 32'h0);
        chk("rst_fault", {31'b0, fault_o}, 32'h0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_be", {28'h0, be_o}, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_ld_data", ld_data_o, 32'h0);
        chk("rst_trap_ld", {trap_ld_o.active, trap_ld_o.mtval[30:0]}, 32'h0);
        chk("rst_trap_st", {trap_st_o.active, trap_st_o.mtval[30:0]}, 32'h0);
        lsu_i = '0;
        rst   = 1'b0;

        mis_op(LSU_LOAD, LSU_W, 32'h0000_1002);
        do_op(LSU_STORE, LSU_B,  32'h0000_2003, 32'h0000_00A5, 1, 1, 32'h0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        do_op(LSU_LOAD,  LSU_H,  32'h0000_3002, 32'h0, 0, 0, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_op(LSU_LOAD,  LSU_HU, 32'h0000_3002, 32'h0, 0, 2, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'h0000_8001);
        do_op(LSU_LOAD,  LSU_B,  32'h0000_2001, 32'h0, 0, 0, 32'h1234_8056, 1'b0, 4'b0010, 32'h0, 32'hFFFF_FF80);
        do_op(LSU_LOAD,  LSU_BU, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_8056, 1'b0, 4'b0010, 32'h0, 32'h0000_0080);
        do_op(LSU_STORE, LSU_H,  32'h0000_2002, 32'h0000_BEEF, 3, 0, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        mis_op(LSU_STORE, LSU_H, 32'h0000_2001);
        do_op(LSU_LOAD,  LSU_W,  32'h0000_4000, 32'h0, 2, 0, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h0);
        do_op(LSU_STORE, LSU_W,  32'h0000_4100, 32'h1122_3344, 0, -1, 32'h0, 1'b0, 4'b1111, 32'h1122_3344, 32'h0);
        #1;
        chk("timeout_idle_bp", {31'b0, lsu_bp_o}, 32'h0);

        // Reset while waiting for the response, then a stray rvalid and gnt in IDLE.
        @(posedge clk); #1;
        clear_bus();
        lsu_i.op_typ = LSU_LOAD; lsu_i.width = LSU_W; lsu_i.addr = 32'h0000_6000; lsu_i.wdata = 32'h0;
        push(K_REQ, cyc + 1, 32'h0000_6000, 4'b1111, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        lsu_i = '0;
        gnt_i = 1'b1;
        @(posedge clk); #1;
        gnt_i = 1'b0;
        chk("wait_bp", {31'b0, lsu_bp_o}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 32'hCAFE_F00D;
        chk("post_rst_bp", {31'b0, lsu_bp_o}, 32'h0);
        @(posedge clk); #1;
        rvalid_i = 1'b0;
        gnt_i    = 1'b1;
        @(posedge clk); #1;
        chk("stray_gnt_req", {31'b0, req_o}, 32'h0);

        do_op(LSU_LOAD, LSU_W, 32'h0000_5000, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        do_op(LSU_LOAD, LSU_B, 32'h0000_2003, 32'h0, 0, 0, 32'h7F00_0000, 1'b0, 4'b1000, 32'h0, 32'h0000_007F);

        @(posedge clk); #1;
        clear_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
